// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^m) multiplier scheduler.
// Holds the default operand/product widths, the multiplier core latency
// and the scheduler FSM state encoding.
package gf2m_pkg;

  localparam int GF_OP_W     = 283;
  localparam int GF_RES_W    = 2 * GF_OP_W;
  localparam int GF_CORE_LAT = 74;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the multiplier scheduler.
// Grants the first asserted request at or after the rotating pointer,
// wrapping at NREQ-1 back to 0. The pointer moves past the winner on an
// accept strobe.
// Ports:
//   clk       clock
//   i_rst_n   asynchronous active-low reset (pointer -> 0)
//   i_en      grant enable (scheduler is idle)
//   i_req     per-requester request vector
//   i_accept  winner accepted this cycle; advance the pointer
//   o_gnt     one-hot grant (zero when disabled or nothing requested)
//   o_idx     index of the winner
//   o_any     at least one request present
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_accept,
  output logic [NREQ-1:0] o_gnt,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_cand;

  // Modulo-NREQ addition; NREQ need not be a power of two.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return ID_W'(sum);
  endfunction

  always_comb begin
    w_cand = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = wrap_add(r_ptr, i);
      if (!o_any && i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    if (i_en && o_any) o_gnt[o_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_accept) begin
      r_ptr <= wrap_add(o_idx, 1);
    end
  end

endmodule

// File: rtl/gf2m_mul_scheduler.sv
// Shares one fixed-latency 283x283 carry-less multiplier core between NREQ
// requesters. One request is accepted at a time (round-robin), its operands
// are registered onto the core, the core is restarted by dropping core_rst
// for CORE_LAT cycles, and the product is returned on a tagged response
// channel with valid/ready backpressure.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake (ready one-hot or zero)
//   req_a/req_b          flattened operands, slice k owned by requester k
//   rsp_valid/rsp_ready  product handshake
//   rsp_id/rsp_c         owner tag and product
//   core_rst             active-high synchronous restart of the core
//   core_a/core_b/core_c core operands and product
// Optional (macro GF2M_SCHED_PERF_EN):
//   perf_ops             completed response handshakes (saturating)
//   perf_stall           RESP cycles with rsp_ready low (saturating)
module gf2m_mul_scheduler
  import gf2m_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int OP_W     = GF_OP_W,
  parameter int RES_W    = GF_RES_W,
  parameter int CORE_LAT = GF_CORE_LAT,
  parameter int ID_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*OP_W-1:0] req_a,
  input  logic [NREQ*OP_W-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [RES_W-1:0]   rsp_c,
  output logic               core_rst,
  output logic [OP_W-1:0]    core_a,
  output logic [OP_W-1:0]    core_b,
  input  logic [RES_W-1:0]   core_c
`ifdef GF2M_SCHED_PERF_EN
  ,
  output logic [31:0]        perf_ops,
  output logic [31:0]        perf_stall
`endif
);

  localparam int CNT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

  sched_state_t     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [OP_W-1:0]  r_core_a, r_core_b;
  logic [RES_W-1:0] r_rsp_c;
  logic [ID_W-1:0]  r_rsp_id;

  logic             w_idle, w_any, w_accept, w_last;
  logic [ID_W-1:0]  w_idx;
  logic [NREQ-1:0]  w_gnt;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && w_any;
  assign w_last   = (r_cnt == CNT_W'(CORE_LAT - 1));

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk      (clk),
    .i_rst_n  (rst),
    .i_en     (w_idle),
    .i_req    (req_valid),
    .i_accept (w_accept),
    .o_gnt    (w_gnt),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // The core runs only in RUN; every other state holds it in restart so a
  // fresh operand pair always starts from a clean pipeline.
  always_comb begin
    w_state_nxt = r_state;
    core_rst    = 1'b1;
    rsp_valid   = 1'b0;
    req_ready   = '0;
    unique case (r_state)
      IDLE: begin
        req_ready = w_gnt;
        if (w_accept) w_state_nxt = LOAD;
      end
      LOAD: w_state_nxt = RUN;
      RUN: begin
        core_rst = 1'b0;
        if (w_last) w_state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_core_a <= '0;
      r_core_b <= '0;
      r_rsp_id <= '0;
      r_rsp_c  <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_core_a <= req_a[w_idx*OP_W +: OP_W];
        r_core_b <= req_b[w_idx*OP_W +: OP_W];
        r_rsp_id <= w_idx;
      end
      if (r_state == LOAD)     r_cnt <= '0;
      else if (r_state == RUN) r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == RUN && w_last) r_rsp_c <= core_c;
    end
  end

  assign core_a = r_core_a;
  assign core_b = r_core_b;
  assign rsp_c  = r_rsp_c;
  assign rsp_id = r_rsp_id;

`ifdef GF2M_SCHED_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_perf_ops, r_perf_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_ops   <= '0;
      r_perf_stall <= '0;
    end else if (r_state == RESP) begin
      if (rsp_ready) r_perf_ops   <= sat_inc(r_perf_ops);
      else           r_perf_stall <= sat_inc(r_perf_stall);
    end
  end

  assign perf_ops   = r_perf_ops;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_gf2m_mul_scheduler.sv
// Testbench for gf2m_mul_scheduler: behavioural multiplier core plus a
// transaction-level reference model of grant order, response timing and
// product values. Define GF2M_SCHED_PERF_EN to also cover the counters.
module tb_gf2m_mul_scheduler;
  import gf2m_pkg::*;

  localparam int NREQ     = 4;
  localparam int OP_W     = GF_OP_W;
  localparam int RES_W    = GF_RES_W;
  localparam int CORE_LAT = GF_CORE_LAT;
  localparam int ID_W     = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*OP_W-1:0] req_a, req_b;
  logic                 rsp_valid, rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [RES_W-1:0]     rsp_c;
  logic                 core_rst;
  logic [OP_W-1:0]      core_a, core_b;
  logic [RES_W-1:0]     core_c;
`ifdef GF2M_SCHED_PERF_EN
  logic [31:0]          perf_ops, perf_stall;
`endif

  gf2m_mul_scheduler #(
    .NREQ(NREQ), .OP_W(OP_W), .RES_W(RES_W), .CORE_LAT(CORE_LAT), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_c(rsp_c),
    .core_rst(core_rst), .core_a(core_a), .core_b(core_b), .core_c(core_c)
`ifdef GF2M_SCHED_PERF_EN
    , .perf_ops(perf_ops), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [RES_W-1:0] clmul(input logic [OP_W-1:0] a,
                                             input logic [OP_W-1:0] b);
    logic [RES_W-1:0] r;
    r = '0;
    for (int i = 0; i < OP_W; i++)
      if (a[i]) r = r ^ ({{(RES_W-OP_W){1'b0}}, b} << i);
    return r;
  endfunction

  function automatic logic [OP_W-1:0] rand_op();
    logic [287:0] t;
    for (int w = 0; w < 9; w++) t[w*32 +: 32] = $urandom;
    return t[OP_W-1:0];
  endfunction

  // Core model: product valid only in the CORE_LAT-th cycle after restart
  // release; any other cycle shows a corrupted value.
  int core_cnt = 0;
  always @(posedge clk) begin
    if (core_rst) core_cnt <= 0;
    else          core_cnt <= core_cnt + 1;
  end
  logic [RES_W-1:0] core_prod;
  assign core_prod = clmul(core_a, core_b);
  assign core_c    = (!core_rst && core_cnt == CORE_LAT - 1) ? core_prod : ~core_prod;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [RES_W-1:0] obs,
                       input logic [RES_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model state
  int               cyc = 0;
  bit               m_busy = 1'b0;
  int               m_ptr = 0;
  int               m_acc = 0;
  int               m_exp_id = 0;
  logic [RES_W-1:0] m_exp_c = '0;
  int               last_gnt = -1;
  int               s_cyc = 0;
  logic             s_rsp_valid, s_core_rst;
  logic [RES_W-1:0] s_rsp_c;
  logic [ID_W-1:0]  s_rsp_id;
  logic [NREQ-1:0]  s_req_ready;

  // One clock cycle: sample, compare with the model, advance the model.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    logic            exp_vld, exp_crst;
    int              gnt, k;
    #1;
    exp_rdy = '0;
    gnt = -1;
    if (!m_busy)
      for (int i = 0; i < NREQ; i++) begin
        k = (m_ptr + i) % NREQ;
        if (gnt < 0 && req_valid[k]) gnt = k;
      end
    if (gnt >= 0) exp_rdy[gnt] = 1'b1;
    exp_vld  = m_busy && (cyc >= m_acc + CORE_LAT + 2);
    exp_crst = !(m_busy && cyc >= m_acc + 2 && cyc <= m_acc + CORE_LAT + 1);
    check("req_ready", RES_W'(req_ready), RES_W'(exp_rdy));
    check("rsp_valid", RES_W'(rsp_valid), RES_W'(exp_vld));
    check("core_rst", RES_W'(core_rst), RES_W'(exp_crst));
    if (exp_vld && rsp_valid) begin
      check_int("rsp_id", int'(rsp_id), m_exp_id);
      check("rsp_c", rsp_c, m_exp_c);
    end
    s_cyc = cyc; s_rsp_valid = rsp_valid; s_core_rst = core_rst;
    s_rsp_c = rsp_c; s_rsp_id = rsp_id; s_req_ready = req_ready;
    last_gnt = gnt;
    if (gnt >= 0) begin
      m_busy   = 1'b1;
      m_acc    = cyc;
      m_exp_id = gnt;
      m_exp_c  = clmul(req_a[gnt*OP_W +: OP_W], req_b[gnt*OP_W +: OP_W]);
      m_ptr    = (gnt + 1) % NREQ;
    end else if (exp_vld && rsp_ready) begin
      m_busy = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_op(input int k, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    req_a[k*OP_W +: OP_W] = a;
    req_b[k*OP_W +: OP_W] = b;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    check("rst core_rst", RES_W'(core_rst), RES_W'(1'b1));
    check("rst rsp_valid", RES_W'(rsp_valid), '0);
    check("rst req_ready", RES_W'(req_ready), '0);
    check("rst rsp_c", rsp_c, '0);
    check("rst rsp_id", RES_W'(rsp_id), '0);
    check("rst core_a", RES_W'(core_a), '0);
    check("rst core_b", RES_W'(core_b), '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_busy = 1'b0;
    m_ptr = 0;
  endtask

  task automatic issue(input int k, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    set_op(k, a, b);
    req_valid[k] = 1'b1;
    for (int n = 0; n < 400; n++) begin
      step();
      if (last_gnt == k) break;
    end
    req_valid[k] = 1'b0;
    check_int("issue grant", last_gnt, k);
  endtask

  task automatic wait_rsp();
    for (int n = 0; n < 200; n++) begin
      step();
      if (s_rsp_valid) break;
    end
    check("wait rsp", RES_W'(s_rsp_valid), RES_W'(1'b1));
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 200 && m_busy; n++) step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows, t_acc, grants, prev;
    int ord[5];
    logic [OP_W-1:0]  hi;
    logic [RES_W-1:0] e;
    ord = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    @(posedge clk);
    #1;

    // Test 1: requester 2, 3*3 -> 5, latency and core restart window
    reset_dut();
    set_op(2, OP_W'(3), OP_W'(3));
    req_valid[2] = 1'b1;
    step();
    check_int("t1 grant", last_gnt, 2);
    req_valid[2] = 1'b0;
    t_acc = m_acc;
    lows = 0;
    for (int n = 0; n < 200; n++) begin
      step();
      if (!s_core_rst) lows++;
      if (s_rsp_valid) break;
    end
    check_int("t1 latency", s_cyc - t_acc, CORE_LAT + 2);
    check_int("t1 core_rst low", lows, CORE_LAT);
    check_int("t1 rsp_id", int'(s_rsp_id), 2);
    check("t1 rsp_c", s_rsp_c, RES_W'(5));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Test 2: all requesters valid from reset, rotation and spacing
    reset_dut();
    rsp_ready = 1'b1;
    for (int k = 0; k < NREQ; k++) set_op(k, rand_op(), rand_op());
    req_valid = '1;
    grants = 0;
    prev = 0;
    for (int n = 0; n < 600 && grants < 5; n++) begin
      step();
      if (last_gnt >= 0) begin
        check_int("t2 order", last_gnt, ord[grants]);
        if (grants > 0) check_int("t2 spacing", s_cyc - prev, CORE_LAT + 3);
        prev = s_cyc;
        grants++;
        set_op(last_gnt, rand_op(), rand_op());
      end
    end
    check_int("t2 grants", grants, 5);
    drain();

    // Test 3: x^282 * x^282 = x^564, long backpressure
    hi = '0;
    hi[OP_W-1] = 1'b1;
    e = '0;
    e[2*OP_W-2] = 1'b1;
    issue(1, hi, hi);
    wait_rsp();
    check("t3 rsp_c", s_rsp_c, e);
    req_valid = '1;
    for (int n = 0; n < 20; n++) begin
      step();
      check("t3 hold rsp_c", s_rsp_c, e);
      check_int("t3 hold rsp_id", int'(s_rsp_id), 1);
      check_int("t3 hold ready", int'(s_req_ready), 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Test 4: reset at RUN cycle 30 discards the product and the pointer
    issue(1, rand_op(), rand_op());
    t_acc = m_acc;
    while (cyc < t_acc + 2 + 30) step();
    reset_dut();
    for (int n = 0; n < 100; n++) step();
    set_op(1, rand_op(), rand_op());
    set_op(3, rand_op(), rand_op());
    req_valid = 4'b1010;
    step();
    check_int("t4 ptr reset", last_gnt, 1);
    req_valid = '0;
    drain();
    issue(3, rand_op(), rand_op());
    wait_rsp();
    check_int("t4 rsp_id", int'(s_rsp_id), 3);
    drain();

    // Test 5: requester 1 pulses valid during RESP and withdraws
    issue(0, rand_op(), rand_op());
    wait_rsp();
    req_valid[1] = 1'b1;
    repeat (3) step();
    req_valid[1] = 1'b0;
    set_op(2, rand_op(), rand_op());
    req_valid[2] = 1'b1;
    repeat (2) step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
    check_int("t5 next grant", last_gnt, 2);
    drain();

    // Test 6: random valid patterns, operands and backpressure
    for (int n = 0; n < 700; n++) begin
      req_valid = NREQ'($urandom_range(0, 15) & $urandom_range(0, 15));
      for (int k = 0; k < NREQ; k++) set_op(k, rand_op(), rand_op());
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

`ifdef GF2M_SCHED_PERF_EN
    // Counters: 3 transactions with 5 stall cycles each
    reset_dut();
    for (int t = 0; t < 3; t++) begin
      issue($urandom_range(0, NREQ-1), rand_op(), rand_op());
      wait_rsp();
      repeat (4) step();
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
    #1;
    check_int("perf_ops", int'(perf_ops), 3);
    check_int("perf_stall", int'(perf_stall), 15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
